// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan controller for an 8-digit seven-segment display plus 8 LEDs.
// Two 4-digit groups are scanned in lock-step: group A (digits 3..0, seg_a_o) and
// group B (digits 7..4, seg_b_o). Each SHOW slot is followed by a BLANK slot.
// NUM is shadow-buffered and only commits on the frame boundary.
// Optional build macro: DISP_AUTOINC_EN (periodic auto-increment of pending NUM).

// Hex nibble to active-high {g,f,e,d,c,b,a}
module seg_hex_dec (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  // Full 16-entry decode table
  always_comb begin
    seg_o = 7'h00;
    case (nib_i)
      4'h0: seg_o = 7'h3F;  4'h1: seg_o = 7'h06;  4'h2: seg_o = 7'h5B;  4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;  4'h5: seg_o = 7'h6D;  4'h6: seg_o = 7'h7D;  4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;  4'h9: seg_o = 7'h6F;  4'hA: seg_o = 7'h77;  4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;  4'hD: seg_o = 7'h5E;  4'hE: seg_o = 7'h79;  4'hF: seg_o = 7'h71;
      default: seg_o = 7'h00;
    endcase
  end
endmodule

module seg_scan_ctrl #(
  parameter int          SCAN_DIV  = 100000,
  parameter int          BLANK_CYC = 1000,
  parameter int          TICK_DIV  = 50000000,
  parameter logic [31:0] INC_STEP  = 32'h1234
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [7:0]  digits_o,
  output logic [6:0]  seg_a_o,
  output logic [6:0]  seg_b_o,
  output logic [7:0]  leds_o
);
  localparam int NUM_GRP = 2;

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] frame_q, frame_d;
  logic [31:0] num_q, num_d, pend_q, pend_d;
  logic        dirty_q, dirty_d;
  logic        en_q, en_d;
  logic [7:0]  mask_q, leds_q;
  logic [31:0] rdata_q, rdata_d;
  logic        boundary;
  logic        wr_num, wr_led, wr_ctrl;
  logic        tick_pulse, autoinc_rd;

  logic [NUM_GRP-1:0][3:0] nib;
  logic [NUM_GRP-1:0][6:0] seg;

  assign wr_num  = we_i && (addr_i == 2'd0);
  assign wr_led  = we_i && (addr_i == 2'd1);
  assign wr_ctrl = we_i && (addr_i == 2'd2);
  // Enable as it will be after this edge, so a clear takes the FSM to IDLE on the same edge
  assign en_d    = wr_ctrl ? wdata_i[0] : en_q;

`ifdef DISP_AUTOINC_EN
  logic        autoinc_q;
  logic [31:0] tick_q;
  assign tick_pulse = autoinc_q && (tick_q == 32'(TICK_DIV - 1));
  assign autoinc_rd = autoinc_q;
  // Tick counter runs only while autoinc is set; clearing autoinc zeroes it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      autoinc_q <= 1'b0;
      tick_q    <= '0;
    end else begin
      if (wr_ctrl) autoinc_q <= wdata_i[1];
      tick_q <= (!autoinc_q || tick_pulse) ? '0 : tick_q + 32'd1;
    end
  end
`else
  assign tick_pulse = 1'b0;
  assign autoinc_rd = 1'b0;
`endif

  // Per-group digit select and decode; group g reads NUM[16g+4*idx +: 4]
  for (genvar g = 0; g < NUM_GRP; g++) begin : gen_grp
    assign nib[g] = num_q[5'(16*g) + {1'b0, idx_q, 2'b00} +: 4];
    seg_hex_dec u_dec (.nib_i(nib[g]), .seg_o(seg[g]));
  end

  // Scan FSM next state: slot timing, index advance, frame boundary detect
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;
    if (!en_d) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SHOW;
          idx_d   = '0;
          cnt_d   = '0;
        end
        SHOW: begin
          if (cnt_q == 32'(SCAN_DIV - 1)) begin
            state_d = BLANK;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 32'd1;
        end
        BLANK: begin
          if (cnt_q == 32'(BLANK_CYC - 1)) begin
            state_d  = SHOW;
            idx_d    = idx_q + 2'd1;
            cnt_d    = '0;
            boundary = (idx_q == 2'd3);
          end else cnt_d = cnt_q + 32'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NUM shadowing: boundary commit, then tick increment, then CPU write has final say
  always_comb begin
    num_d   = num_q;
    pend_d  = pend_q;
    dirty_d = dirty_q;
    frame_d = boundary ? frame_q + 16'd1 : frame_q;
    if (boundary && dirty_q) begin
      num_d   = pend_q;
      dirty_d = 1'b0;
    end
    if (tick_pulse) begin
      pend_d  = pend_q + INC_STEP;
      dirty_d = 1'b1;
    end
    if (wr_num) begin
      pend_d = wdata_i;
      if (en_q) dirty_d = 1'b1;
      else begin
        num_d   = wdata_i;
        dirty_d = 1'b0;
      end
    end
  end

  // Read mux, registered one cycle later
  always_comb begin
    case (addr_i)
      2'd0:    rdata_d = num_q;
      2'd1:    rdata_d = {24'h0, leds_q};
      2'd2:    rdata_d = {16'h0, mask_q, 6'h0, autoinc_rd, en_q};
      default: rdata_d = {frame_q, 12'h0, dirty_q, state_q == BLANK, idx_q};
    endcase
  end

  // State and register file
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      frame_q <= '0;
      num_q   <= '0;
      pend_q  <= '0;
      dirty_q <= 1'b0;
      en_q    <= 1'b1;
      mask_q  <= '0;
      leds_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      num_q   <= num_d;
      pend_q  <= pend_d;
      dirty_q <= dirty_d;
      en_q    <= en_d;
      if (wr_ctrl) mask_q <= wdata_i[15:8];
      if (wr_led)  leds_q <= wdata_i[7:0];
      rdata_q <= rdata_d;
    end
  end

  // Display drive: only in SHOW, with per-digit blanking by the mask
  always_comb begin
    digits_o = '0;
    seg_a_o  = '0;
    seg_b_o  = '0;
    if (state_q == SHOW) begin
      if (!mask_q[{1'b0, idx_q}]) begin
        digits_o[{1'b0, idx_q}] = 1'b1;
        seg_a_o = seg[0];
      end
      if (!mask_q[{1'b1, idx_q}]) begin
        digits_o[{1'b1, idx_q}] = 1'b1;
        seg_b_o = seg[1];
      end
    end
  end

  assign rdata_o = rdata_q;
  assign leds_o  = leds_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus pushes {cycle, signal, value},
// a negedge monitor pops and compares entries due in the current cycle.
module tb_seg_scan_ctrl;
  localparam int SCAN_DIV = 4, BLANK_CYC = 2, TICK_DIV = 10;

  logic        clk = 1'b0, rst_n = 1'b0, we = 1'b0;
  logic [1:0]  addr = 2'd3;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  digits, leds;
  logic [6:0]  seg_a, seg_b;

  seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .TICK_DIV(TICK_DIV),
                  .INC_STEP(32'h1234)) dut (
    .clk_i(clk), .rst_ni(rst_n), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .digits_o(digits), .seg_a_o(seg_a), .seg_b_o(seg_b), .leds_o(leds));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int k; logic [31:0] v; string n; } exp_t;
  exp_t sb[$];
  int nvec = 0, nfail = 0;

  function automatic logic [31:0] dut_val(int k);
    case (k)
      0: return {24'h0, digits};
      1: return {25'h0, seg_a};
      2: return {25'h0, seg_b};
      3: return {24'h0, leds};
      default: return rdata;
    endcase
  endfunction

  // Monitor: compare every scoreboard entry due this cycle
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].c == cyc) begin
        nvec++;
        if (dut_val(sb[i].k) !== sb[i].v) begin
          nfail++;
          $display("FAIL %s @cyc %0d: got %h want %h", sb[i].n, cyc, dut_val(sb[i].k), sb[i].v);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push_exp(int c, int k, logic [31:0] v, string n);
    sb.push_back('{c, k, v, n});
  endtask

  task automatic disp(int c, logic [7:0] d, logic [6:0] a, logic [6:0] b, string n);
    push_exp(c, 0, {24'h0, d}, {n, ".digits"});
    push_exp(c, 1, {25'h0, a}, {n, ".seg_a"});
    push_exp(c, 2, {25'h0, b}, {n, ".seg_b"});
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(int n, logic [1:0] a, logic [31:0] d);
    wait_cyc(n);
    we = 1'b1; addr = a; wdata = d;
    wait_cyc(n + 1);
    we = 1'b0; addr = 2'd3;
  endtask

  task automatic bus_rd(int n, logic [1:0] a);
    wait_cyc(n);
    addr = a;
    wait_cyc(n + 1);
    addr = 2'd3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    // Reset values
    disp(2, 8'h00, 7'h00, 7'h00, "reset");
    push_exp(2, 3, 32'h0, "reset.leds");
    push_exp(2, 4, 32'h0, "reset.rdata");
    wait_cyc(3);
    rst_n = 1'b1;

    // Frame 0 (starts cyc 4): NUM=0, slots every 6 cycles
    disp(4, 8'h11, 7'h3F, 7'h3F, "f0s0");
    push_exp(7, 0, 32'h11, "f0s0_last");
    push_exp(8, 0, 32'h00, "f0blank0");
    push_exp(9, 0, 32'h00, "f0blank1");
    disp(10, 8'h22, 7'h3F, 7'h3F, "f0s1");

    // NUM write mid-frame: held in pending, dirty set
    push_exp(14, 4, 32'h0000_0009, "status_dirty");
    disp(16, 8'h44, 7'h3F, 7'h3F, "f0s2_held");
    bus_wr(12, 2'd0, 32'hF00A_0018);
    push_exp(21, 4, 32'h0, "num_committed_old");
    bus_rd(20, 2'd0);
    push_exp(23, 3, 32'hA5, "leds");
    bus_wr(22, 2'd1, 32'hFFFF_FFA5);
    nvec++;
    if (leds !== 8'hA5) begin
      nfail++;
      $display("FAIL leds_direct @cyc %0d: got %h want a5", cyc, leds);
    end

    // Frame 1 (cyc 28): committed value on display
    disp(28, 8'h11, 7'h7F, 7'h77, "f1s0");
    push_exp(30, 4, 32'h0001_0000, "status_f1_clean");
    push_exp(32, 4, 32'hF00A_0018, "num_committed_new");
    bus_rd(31, 2'd0);
    disp(34, 8'h22, 7'h06, 7'h3F, "f1s1");
    disp(40, 8'h44, 7'h3F, 7'h3F, "f1s2");
    bus_wr(40, 2'd0, 32'h0000_0002);
    disp(46, 8'h88, 7'h3F, 7'h71, "f1s3");

    // NUM write on the boundary edge (P52): old pending commits, new stays dirty
    disp(52, 8'h11, 7'h5B, 7'h3F, "f2s0_oldpend");
    push_exp(54, 4, 32'h0002_0008, "status_f2_still_dirty");
    bus_wr(51, 2'd0, 32'h0000_0003);
    disp(76, 8'h11, 7'h4F, 7'h3F, "f3s0_newpend");

    // Mask digits 0 and 4
    disp(78, 8'h00, 7'h00, 7'h00, "mask_s0");
    push_exp(79, 4, 32'h0003_0000, "status_f3_clean");
    bus_wr(77, 2'd2, 32'hABCD_1101);
    disp(82, 8'h22, 7'h3F, 7'h3F, "mask_s1");
    push_exp(84, 4, 32'h0000_1101, "ctrl_readback");
    bus_rd(83, 2'd2);
    disp(100, 8'h00, 7'h00, 7'h00, "mask_f4s0");
    disp(102, 8'h11, 7'h4F, 7'h3F, "unmask_f4s0");
    bus_wr(101, 2'd2, 32'h0000_0001);

    // Clear enable during SHOW idx 2 (cyc 112..115)
    disp(114, 8'h00, 7'h00, 7'h00, "disabled");
    push_exp(115, 4, 32'h0004_0000, "status_idle");
    bus_wr(113, 2'd2, 32'h0);
    push_exp(117, 0, 32'h0, "idle_digits");
    bus_wr(116, 2'd0, 32'h0000_0005);
    push_exp(119, 4, 32'h0000_0005, "num_direct");
    bus_rd(118, 2'd0);
    push_exp(120, 4, 32'h0004_0000, "status_direct_clean");
    disp(121, 8'h11, 7'h6D, 7'h3F, "reenable");
    bus_wr(120, 2'd2, 32'h0000_0001);

    // Reset mid-operation
    push_exp(125, 0, 32'h0, "midreset.digits");
    push_exp(125, 3, 32'h0, "midreset.leds");
    push_exp(125, 4, 32'h0, "midreset.rdata");
    wait_cyc(125);
    rst_n = 1'b0;
    wait_cyc(127);
    rst_n = 1'b1;
    disp(128, 8'h11, 7'h3F, 7'h3F, "postreset_s0");
    bus_wr(128, 2'd2, 32'h0000_0003);
`ifdef DISP_AUTOINC_EN
    push_exp(131, 4, 32'h0000_0003, "ctrl_autoinc");
    push_exp(141, 4, 32'h0000_000A, "status_tick_dirty");
`else
    push_exp(131, 4, 32'h0000_0001, "ctrl_autoinc_ignored");
    push_exp(141, 4, 32'h0000_0002, "status_no_tick");
`endif
    bus_rd(130, 2'd2);
`ifdef DISP_AUTOINC_EN
    // Pulses at P139,149,...; boundary at P152 commits 2*0x1234
    disp(152, 8'h11, 7'h7F, 7'h3F, "ai_f1s0");
    push_exp(153, 4, 32'h0000_2468, "ai_commit1");
    bus_rd(152, 2'd0);
    disp(158, 8'h22, 7'h7D, 7'h3F, "ai_f1s1");
    push_exp(177, 4, 32'h0000_48D0, "ai_commit2");
    bus_rd(176, 2'd0);
    // CPU write coincides with pulse at P179: write wins, increment dropped
    bus_wr(178, 2'd0, 32'h0000_0007);
    push_exp(201, 4, 32'h0000_246F, "ai_write_wins");
    bus_rd(200, 2'd0);
`endif
    wait_cyc(205);
    nvec++;
    if (leds !== 8'h00) begin
      nfail++;
      $display("FAIL leds_after_reset @cyc %0d: got %h want 00", cyc, leds);
    end
    nvec++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard not drained: %0d entries left", sb.size());
    end
    foreach (sb[i]) begin
      nvec++;
      nfail++;
      $display("FAIL %s: never checked (due cyc %0d, want %h)", sb[i].n, sb[i].c, sb[i].v);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
